// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the CSR command/response streams, the bridge and the APB4 slave.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Command stream
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_strb;

  // Response stream
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  // APB4
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready CSR command stream to APB4 bridge: command FIFO, one outstanding transfer,
// in-order responses and a watchdog that aborts transfers to a hung slave.
module apb_master_bridge #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_master_bridge_if.master  bus
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO (pointers carry one extra wrap bit to tell full from empty)
  // ---------------------------------------------------------------------------
  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;
  logic          fifo_full, fifo_empty;
  logic          cmd_ready;
  logic          push, pop;
  cmd_t          cmd_in, head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  // Held low during reset so nothing is accepted before the bridge is live.
  assign cmd_ready  = rst_n && !fifo_full;
  assign push       = bus.cmd_valid && cmd_ready;

  assign cmd_in.write = bus.cmd_write;
  assign cmd_in.addr  = bus.cmd_addr;
  assign cmd_in.wdata = bus.cmd_wdata;
  assign cmd_in.strb  = bus.cmd_strb;
  assign head         = mem_q[rptr_q[PW-1:0]];

  assign wptr_d = wptr_q + {{PW{1'b0}}, push};
  assign rptr_d = rptr_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PW-1:0]] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    wd_d     = wd_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // A ready slave wins over a watchdog expiring in the same cycle.
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          state_d = StResp;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every pop launches a fresh transfer; reads drive zero data and strobes.
    if (pop) begin
      paddr_d  = head.addr;
      pwrite_d = head.write;
      pwdata_d = head.write ? head.wdata : '0;
      pstrb_d  = head.write ? head.strb : '0;
      wd_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      wd_q     <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wd_q     <= wd_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state so reset drops psel/penable immediately)
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = (state_q == StSetup) || (state_q == StAccess);
  assign bus.penable   = (state_q == StAccess);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_penable_needs_psel: assert property (@(posedge clk) disable iff (!rst_n)
    bus.penable |-> bus.psel);

  a_setup_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.psel && !bus.penable) |=> (bus.psel && bus.penable));

  a_access_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.penable |=> ($stable(bus.paddr) && $stable(bus.pwrite) &&
                     $stable(bus.pwdata) && $stable(bus.pstrb)));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err)));

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: APB slave model plus in-order scoreboards
// for APB transfers and responses, driven by one task per scenario.
module tb_apb_master_bridge;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TMO     = 256;
  localparam logic [31:0] ERR_ADDR  = 32'h0000_0044;
  localparam logic [31:0] HANG_ADDR = 32'h0000_BAD0;
  localparam logic [31:0] ERR_DATA  = 32'hE0E0_E0E0;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.AW(AW), .DW(DW)) bus ();

  apb_master_bridge #(
    .AW        (AW),
    .DW        (DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  apb_exp_t    apb_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] slv_mem [bit [31:0]];
  int          n_cmp      = 0;
  int          n_bad      = 0;
  int          rsp_cnt    = 0;
  int          slave_wait = 0;
  int          acc_cnt    = 0;
  apb_exp_t    cur;
  rsp_exp_t    got_rsp;
  logic [31:0] slv_tmp;

  // APB slave: decides pready for the coming edge; ERR_ADDR errors, HANG_ADDR never answers.
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      if (acc_cnt >= slave_wait && bus.paddr != HANG_ADDR) begin
        bus.pready  = 1'b1;
        bus.pslverr = (bus.paddr == ERR_ADDR);
        if (bus.pslverr) begin
          bus.prdata = ERR_DATA;
        end else if (bus.pwrite) begin
          bus.prdata = 32'h5A5A_5A5A;
          slv_tmp = slv_mem.exists(bus.paddr) ? slv_mem[bus.paddr] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (bus.pstrb[b]) slv_tmp[8*b +: 8] = bus.pwdata[8*b +: 8];
          end
          slv_mem[bus.paddr] = slv_tmp;
        end else begin
          bus.prdata = slv_mem.exists(bus.paddr) ? slv_mem[bus.paddr] : 32'h0;
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hBADB_ADBA;
      end
      acc_cnt++;
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
      acc_cnt     = 0;
    end
  end

  // Scoreboard: pops expected APB transfers at SETUP and expected responses at handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.psel && !bus.penable) begin
        n_cmp++;
        if (apb_q.size() == 0) begin
          n_bad++;
          $display("FAIL apb_unexpected: got transfer to %h, required none", bus.paddr);
        end else begin
          cur = apb_q.pop_front();
          if ({bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb} !== cur) begin
            n_bad++;
            $display("FAIL apb_setup: got %h required %h",
                     {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb}, cur);
          end
        end
      end else if (bus.psel && bus.penable) begin
        n_cmp++;
        if ({bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb} !== cur) begin
          n_bad++;
          $display("FAIL apb_hold: got %h required %h",
                   {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb}, cur);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cnt++;
        n_cmp++;
        if (rsp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata %h err %b, required none",
                   bus.rsp_rdata, bus.rsp_err);
        end else begin
          got_rsp = rsp_q.pop_front();
          if ({bus.rsp_rdata, bus.rsp_err} !== got_rsp) begin
            n_bad++;
            $display("FAIL rsp_data: got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_err,
                     got_rsp.rdata, got_rsp.err);
          end
        end
      end
    end
  end

  // Pushes expectations, then holds cmd_valid until accepted (bounded).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output bit ok);
    apb_exp_t    e;
    rsp_exp_t    r;
    logic [31:0] old;
    bit          acc;
    e.write = w;
    e.addr  = a;
    e.wdata = w ? d : 32'h0;
    e.strb  = w ? s : 4'h0;
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    if (a == HANG_ADDR) begin
      r = {32'h0, 1'b1};
    end else if (a == ERR_ADDR) begin
      r = {(w ? 32'h0 : ERR_DATA), 1'b1};
    end else if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      end
      ref_mem[a] = old;
      r = {32'h0, 1'b0};
    end else begin
      r = {old, 1'b0};
    end
    apb_q.push_back(e);
    rsp_q.push_back(r);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && apb_q.size() == 0 && !bus.rsp_valid && !bus.psel) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_apb_ctl: got psel %b penable %b required 0 0", bus.psel, bus.penable);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rsp: got %b %b %h required 0 0 0", bus.rsp_valid, bus.rsp_err,
               bus.rsp_rdata);
    end
    n_cmp++;
    if ({bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb} !== 69'h0) begin
      n_bad++;
      $display("FAIL reset_apb_data: got %h required 0",
               {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb});
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cmd_ready_low: got %b required 0", bus.cmd_ready);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cmd_ready_high: got %b required 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    bit ok;
    bus.rsp_ready = 1'b1;
    slave_wait    = 0;
    send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wr_accept: got no accept required accept"); end
    @(negedge clk);
    n_cmp++;
    if (bus.psel !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_idle_cycle: got psel %b required 0", bus.psel);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_setup: got psel %b penable %b required 1 0", bus.psel, bus.penable);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_access: got psel %b penable %b required 1 1", bus.psel, bus.penable);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.psel !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp_latency: got rsp_valid %b psel %b required 1 0", bus.rsp_valid,
               bus.psel);
    end
    drain(50, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wr_drain: got busy required idle"); end
  endtask

  task automatic test_read_wait();
    bit ok;
    int acc;
    bit zero_ok;
    bus.rsp_ready = 1'b1;
    slave_wait    = 5;
    acc           = 0;
    zero_ok       = 1'b1;
    send(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.psel) begin
        if (bus.penable) acc++;
        if (bus.pwdata !== 32'h0 || bus.pstrb !== 4'h0) zero_ok = 1'b0;
      end
      if (bus.rsp_valid) break;
    end
    n_cmp++;
    if (acc != 6) begin
      n_bad++;
      $display("FAIL rd_wait_cycles: got %0d access cycles required 6", acc);
    end
    n_cmp++;
    if (!zero_ok) begin
      n_bad++;
      $display("FAIL rd_zero_wdata: got nonzero pwdata/pstrb required 0");
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: got %b %h %b required 1 deadbeef 0", bus.rsp_valid,
               bus.rsp_rdata, bus.rsp_err);
    end
    drain(50, ok);
    slave_wait = 0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rd_drain: got busy required idle"); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit ok6;
    int base;
    base          = rsp_cnt;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(i[0], 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL full_accept_%0d: got no accept required accept", i); end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL full_ready: got cmd_ready %b rsp_valid %b required 0 1", bus.cmd_ready,
               bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    fork
      send(1'b1, 32'h114, 32'hA000_0005, 4'hF, ok6);
      begin
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL full_hold: got cmd_ready %b required 0", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    n_cmp++;
    if (!ok6) begin n_bad++; $display("FAIL full_sixth: got no accept required accept"); end
    drain(200, ok);
    n_cmp++;
    if (!ok || rsp_cnt - base != 6) begin
      n_bad++;
      $display("FAIL full_drain: got %0d responses required 6", rsp_cnt - base);
    end
  endtask

  task automatic test_slave_error();
    bit ok;
    int base;
    base          = rsp_cnt;
    bus.rsp_ready = 1'b1;
    send(1'b0, ERR_ADDR, 32'h0, 4'h0, ok);
    send(1'b1, 32'h20, 32'h1234_5678, 4'h3, ok);
    send(1'b0, 32'h20, 32'h0, 4'h0, ok);
    drain(100, ok);
    n_cmp++;
    if (!ok || rsp_cnt - base != 3) begin
      n_bad++;
      $display("FAIL err_count: got %0d responses required 3", rsp_cnt - base);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int acc;
    bus.rsp_ready = 1'b0;
    acc           = 0;
    send(1'b0, HANG_ADDR, 32'h0, 4'h0, ok);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++;
      else if (acc > 0) break;
    end
    n_cmp++;
    if (acc != 256) begin
      n_bad++;
      $display("FAIL tmo_cycles: got %0d access cycles required 256", acc);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL tmo_rsp: got %b %b %h required 1 1 0", bus.rsp_valid, bus.rsp_err,
               bus.rsp_rdata);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    send(1'b1, 32'h30, 32'hCAFE_F00D, 4'hC, ok);
    send(1'b0, 32'h30, 32'h0, 4'h0, ok);
    drain(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_recover: got busy required idle"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit quiet;
    int base;
    bus.rsp_ready = 1'b1;
    send(1'b0, HANG_ADDR, 32'h0, 4'h0, ok);
    send(1'b0, 32'h10, 32'h0, 4'h0, ok);
    send(1'b0, 32'h20, 32'h0, 4'h0, ok);
    @(negedge clk);
    n_cmp++;
    if (bus.penable !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_access: got penable %b required 1", bus.penable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %b %b %b required 0 0 0", bus.psel, bus.penable,
               bus.rsp_valid);
    end
    apb_q.delete();
    rsp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    base  = rsp_cnt;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.psel !== 1'b0 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL rst_mid_stale: got activity after reset required none");
    end
    @(posedge clk);
    #1;
    send(1'b0, 32'h20, 32'h0, 4'h0, ok);
    drain(100, ok);
    n_cmp++;
    if (!ok || rsp_cnt - base != 1) begin
      n_bad++;
      $display("FAIL rst_mid_after: got %0d responses required 1", rsp_cnt - base);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_fifo_full();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion required completion");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready CSR command stream (from a bench sequencer or a CPU-side port) into APB4 transfers toward the CSR register block.
- Returns one response per command: read data plus an error flag.
- Buffers commands in a small FIFO.
- Allows exactly one outstanding APB transfer at a time, and adds a watchdog so a hung slave cannot stall the bus.

Parameters:
- AW, 32, address width (matches the package APB_AW).
- DW, 32, data width (matches the package APB_DW); must be a multiple of 8.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 256, maximum ACCESS cycles with pready low before the transfer is aborted; at least 2.

Ports:
- clk  in  1  Single clock for all logic.
- rst_n  in  1  Reset, asynchronous, active-low.
- cmd_valid  in  1  Command valid.
- cmd_ready  out  1  Command accept; equals !fifo_full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  Byte address.
- cmd_wdata  in  DW  Write data.
- cmd_strb  in  DW/8  Write byte strobes.
- rsp_valid  out  1  Response valid.
- rsp_ready  in  1  Response accept.
- rsp_rdata  out  DW  Read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = pslverr or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pstrb  out  DW/8  APB strobes.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- **Reset (async, rst_n low):**
  - FIFO emptied, FSM to IDLE, watchdog counter cleared.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, pstrb, rsp_rdata = 0; cmd_ready = 0 while rst_n is low, 1 after release.
  - An assertion mid-transfer drops psel/penable immediately and discards that transfer and any queued commands; no response is produced for them.
- **Command FIFO:**
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full; there is no push-through when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are both legal when not full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - If the FIFO is non-empty, pop the head, register paddr/pwrite/pwdata/pstrb, go to SETUP.
  - On a read, pwdata = 0 and pstrb = 0.
- **SETUP:** psel = 1, penable = 0, for exactly one cycle, then go to ACCESS.
- **ACCESS:**
  - psel = 1, penable = 1.
  - paddr, pwrite, pwdata and pstrb are held stable from SETUP until completion.
  - Completion occurs at the edge where pready = 1:
    - capture rsp_rdata = pwrite ? 0 : prdata;
    - capture rsp_err = pslverr;
    - drop psel and penable;
    - go to RESP.
  - The watchdog counts ACCESS cycles with pready = 0. When the count reaches TIMEOUT:
    - abort the transfer and drop psel/penable;
    - set rsp_err = 1 and rsp_rdata = 0;
    - go to RESP.
  - If pready and the timeout condition coincide, pready wins.
- **RESP:**
  - rsp_valid = 1, with rsp_rdata/rsp_err held until rsp_valid && rsp_ready.
  - On that handshake: go to SETUP directly (popping the next command) if the FIFO is non-empty, otherwise go to IDLE.
  - The watchdog clears on entry to SETUP.
- **Latency:**
  - Command pushed into an empty FIFO while idle at edge t: the pop happens in the IDLE cycle following t, so psel rises after edge t+1 and penable after edge t+2.
  - With pready held high, completion occurs at edge t+3, rsp_valid is asserted after t+3, and minimum command-to-response is 3 cycles.
  - Back-to-back commands with rsp_ready tied high: the next SETUP immediately follows the RESP cycle, i.e. one idle-bus cycle (RESP) between transfers.
- **Ordering:** responses are returned strictly in command order, one per command.

Test Plan:
- **Single write:** write 0x10 = 0xDEADBEEF, strb 0xF, pready = 1 → psel high 1 cycle before penable; paddr = 0x10, pwrite = 1, pwdata stable across SETUP/ACCESS; rsp_err = 0, rsp_rdata = 0, 3 cycles after acceptance.
- **Read with wait states:** read 0x10; pready low 5 ACCESS cycles, then high with prdata = 0xDEADBEEF → rsp_rdata = 0xDEADBEEF, rsp_err = 0; pstrb = 0 and pwdata = 0 throughout.
- **FIFO full and backpressure:** with rsp_ready = 0, push 6 commands → cmd_ready drops after 4 are queued while the first is in flight; releasing rsp_ready drains all of them in order, with addresses matching push order.
- **Slave error:** read 0x44 with pslverr = 1 on the pready cycle → rsp_err = 1; the next command still executes normally.
- **Timeout:** pready held 0 → psel/penable drop after exactly 256 ACCESS cycles; rsp_err = 1, rsp_rdata = 0; the following transfer completes cleanly.
- **Reset mid-ACCESS:** assert rst_n low during ACCESS with 2 commands queued → psel/penable/rsp_valid go 0 asynchronously; after release, no stale response appears and the FIFO is empty.
